// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART blocks: receiver FSM encoding,
// register offsets and STATUS bit positions.
package apb_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam logic REG_RXDATA = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVR       = 2;
    localparam int STAT_FERR      = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with wrap-bit pointers; a push while full is accepted only
// when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head_data = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d  = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d  = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // When full, the written slot is the head being popped this same cycle.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/apb_uart_rx.sv
// 8N1 UART receiver with an APB slave exposing RXDATA (pop on read) and
// STATUS (sticky FERR/OVR, write-one-to-clear).
//
// state | meaning
// IDLE  | waiting for a synchronized falling edge
// START | timing to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits LSB first at mid-bit
// STOP  | sampling stop bit; push byte or flag framing error
module apb_uart_rx
    import apb_uart_pkg::*;
#(
    parameter int BUS_WIDTH    = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] S_PADDR,
    input  logic                 S_PWRITE,
    input  logic                 S_PSELx,
    input  logic                 S_PENABLE,
    input  logic [BUS_WIDTH-1:0] S_PWDATA,
    output logic [BUS_WIDTH-1:0] S_PRDATA,
    output logic                 S_PREADY,
    input  logic                 rx_wire,
    output logic                 rx_irq
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic              rx_line, rx_fall;
    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_done, frame_err;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_head;
    logic              ferr_q, ferr_d, ovr_q, ovr_d, irq_q;
    logic              apb_access, rd_access, stat_wr, ovr_set;
    logic [BUS_WIDTH-1:0] status_word, prdata;
    logic              unused_bus;

    assign rx_line = rx_s2_q;
    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_wire;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rx_fall) state_d = ST_START;
            ST_START: if (cnt_q == CNT_HALF) state_d = rx_line ? ST_IDLE : ST_DATA;
            ST_DATA:  if (cnt_q == CNT_LAST && idx_q == 3'd7) state_d = ST_STOP;
            ST_STOP:  if (cnt_q == CNT_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q + CNT_ONE;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) cnt_d = '0;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    shift_d = {rx_line, shift_q[7:1]};
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    byte_done = rx_line;
                    frame_err = ~rx_line;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (byte_done),
        .push_data (shift_q),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign apb_access = S_PSELx & S_PENABLE;
    assign rd_access  = apb_access & ~S_PWRITE;
    assign stat_wr    = apb_access & S_PWRITE & (S_PADDR[0] == REG_STATUS);
    assign fifo_pop   = rd_access & (S_PADDR[0] == REG_RXDATA) & ~fifo_empty;
    assign ovr_set    = byte_done & fifo_full & ~fifo_pop;

    // Set beats clear when both land in the same cycle.
    assign ferr_d = frame_err | (ferr_q & ~(stat_wr & S_PWDATA[STAT_FERR]));
    assign ovr_d  = ovr_set   | (ovr_q  & ~(stat_wr & S_PWDATA[STAT_OVR]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
            irq_q  <= ~fifo_empty;
        end
    end

    always_comb begin
        status_word                 = '0;
        status_word[STAT_NOT_EMPTY] = ~fifo_empty;
        status_word[STAT_FULL]      = fifo_full;
        status_word[STAT_OVR]       = ovr_q;
        status_word[STAT_FERR]      = ferr_q;
    end

    always_comb begin
        prdata = '0;
        if (reset && S_PSELx) begin
            if (S_PADDR[0] == REG_RXDATA) begin
                if (!fifo_empty) prdata[7:0] = fifo_head;
            end else begin
                prdata = status_word;
            end
        end
    end

    assign S_PRDATA = prdata;
    assign S_PREADY = reset & apb_access;
    assign rx_irq   = irq_q;

    assign unused_bus = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA[BUS_WIDTH-1:4], S_PWDATA[1:0]};

endmodule
